accum_bcd_display: RTL and testbench
====================================

Name: accum_bcd_display

Overview:
- Downstream display stage for the 8-bit accumulator (accumulated value plus overflow bit).
- On a start pulse, captures the value and overflow flag, then converts the value to three BCD digits with an iterative shift-add-3 (double-dabble) sequencer.
- Drives three active-low seven-segment displays (HEX2 = hundreds, HEX1 = tens, HEX0 = units) with leading-zero blanking and an overflow message.
- The displays hold the last completed result; they change only at conversion completion.

Parameters:
- BLANK_LZ, 1, when 1 blank leading zero digits (hundreds, then tens); units digit always shown.
- WIDTH, 8, input value width; the block is verified at 8 only, and 3 BCD digits must cover 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  synchronous active-high reset
- value  input  WIDTH  unsigned accumulator value
- ovf  input  1  accumulator overflow flag
- start  input  1  request conversion; sampled only in IDLE
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when the displays update
- HEX0  output  7  units display, active-low, bit6..0 = g..a
- HEX1  output  7  tens display, active-low
- HEX2  output  7  hundreds display, active-low

Behaviour:
- Reset (clr=1 at a clk edge, in any state): state=IDLE; busy=0; done=0; HEX0/1/2=7'h7F (all off); shift register and iteration counter cleared.
- Reset mid-conversion abandons the conversion. The displays go blank; no done pulse is issued.
- States: IDLE, SHIFT, LOAD.
- IDLE:
  - If start=1 at edge N: capture value into a 20-bit register {bcd[11:0], bin[7:0]}={12'd0,value}, capture ovf into ovf_q, set cnt=0, go to SHIFT. busy=1 from edge N.
  - Otherwise remain in IDLE.
- SHIFT, each edge:
  - Every BCD nibble >=5 gets +3, then the whole register shifts left by 1.
  - cnt increments.
  - After the 8th iteration (edge N+8), go to LOAD.
- LOAD (edge N+9):
  - Write HEX0..2 from the digits (or the overflow message).
  - Assert done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: the new display is valid, with done=1, in the cycle after edge N+9. busy is high for 9 cycles.
- start while busy (SHIFT or LOAD) is ignored; there is no queuing. A start held high across LOAD is accepted at the first IDLE edge.
- value and ovf may change freely after the capture edge without affecting the conversion in flight.
- Digit encoding, active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Blanking (BLANK_LZ=1):
  - HEX2 is blank if the hundreds digit is 0.
  - HEX1 is blank if the hundreds and tens digits are both 0.
  - HEX0 is never blank.
  - With BLANK_LZ=0, all digits are always shown.
- Overflow: if ovf_q=1, display "OFL" instead of the digits, regardless of value:
  - HEX2 = O (1000000)
  - HEX1 = F (0001110)
  - HEX0 = L (1000111)
- Simultaneous clr and start: clr wins.

Decomposition:
- Shared package accum_disp_pkg holds:
  - the state enum (IDLE, SHIFT, LOAD)
  - SEG_BLANK, SEG_O, SEG_F, SEG_L constants
  - the digit-to-segment lookup constants
  - ITER_COUNT=8
- One sub-module, seg7_decode: combinational 4-bit digit plus blank input to 7-bit active-low segments. It is instantiated three times; the overflow override is muxed after it.

Test Plan:
- Reset then idle: clr=1 for 2 cycles -> HEX0/1/2=7F, busy=0, done=0; no change without start.
- value=255, ovf=0, start pulse -> busy high 9 cycles; done at N+9; HEX2=0100100, HEX1=0010010, HEX0=0010010.
- Blanking at BLANK_LZ=1:
  - value=0 -> HEX2=HEX1=1111111, HEX0=1000000.
  - value=107 -> HEX2=1111001, HEX1=1000000 (interior zero shown), HEX0=1111000.
- value=200, ovf=1, start -> HEX2=1000000, HEX1=0001110, HEX0=1000111.
- start at N with value=42; change value to 99 and pulse start again at N+3 -> second start ignored; display 42 (HEX1=0011001, HEX0=0100100) with a single done pulse.
- Reset mid-conversion: start with value=128, clr at N+4 -> HEX all 7F, no done pulse, busy=0 at N+5; a new start with value=9 then gives HEX0=0010000.

Source files
------------

// File: rtl/accum_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accum_disp_pkg
//  Description : Shared types and constants for the accumulator BCD display
//                stage: FSM state encoding, seven-segment patterns
//                (active-low, bit6..0 = g..a) and the iteration count.
//  Revision    : 1.0 - initial release
// ============================================================================
package accum_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // One double-dabble iteration per input bit
    localparam int ITER_COUNT = 8;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_L     = 7'b1000111;

    localparam logic [6:0] SEG_D0 = 7'b1000000;
    localparam logic [6:0] SEG_D1 = 7'b1111001;
    localparam logic [6:0] SEG_D2 = 7'b0100100;
    localparam logic [6:0] SEG_D3 = 7'b0110000;
    localparam logic [6:0] SEG_D4 = 7'b0011001;
    localparam logic [6:0] SEG_D5 = 7'b0010010;
    localparam logic [6:0] SEG_D6 = 7'b0000010;
    localparam logic [6:0] SEG_D7 = 7'b1111000;
    localparam logic [6:0] SEG_D8 = 7'b0000000;
    localparam logic [6:0] SEG_D9 = 7'b0010000;

    // Non-decimal nibbles cannot occur after a valid conversion; show blank
    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_D0;
            4'd1:    seg = SEG_D1;
            4'd2:    seg = SEG_D2;
            4'd3:    seg = SEG_D3;
            4'd4:    seg = SEG_D4;
            4'd5:    seg = SEG_D5;
            4'd6:    seg = SEG_D6;
            4'd7:    seg = SEG_D7;
            4'd8:    seg = SEG_D8;
            4'd9:    seg = SEG_D9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational BCD digit to active-low seven-segment decoder
//                with a blank override.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import accum_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank wins over the digit pattern
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = digit_to_seg(digit);
        end
    end

endmodule
`default_nettype wire

// File: rtl/accum_bcd_display.sv
`default_nettype none
// ============================================================================
//  Module      : accum_bcd_display
//  Description : Captures the accumulator value and overflow flag on start,
//                converts the value to three BCD digits by iterative
//                shift-add-3, then drives three active-low seven-segment
//                displays with leading-zero blanking and an "OFL" message.
//                Displays change only when a conversion completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module accum_bcd_display
    import accum_disp_pkg::*;
#(
    parameter int BLANK_LZ = 1,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] value,
    input  logic             ovf,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2
);

    // Three BCD nibbles sit above the binary field in one shift register
    localparam int SR_W  = 12 + WIDTH;
    localparam int CNT_W = $clog2(ITER_COUNT + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SR_W-1:0]  r_sr;
    logic [SR_W-1:0]  w_sr_adj;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last_iter;
    logic             r_ovf;
    logic             r_done;
    logic [6:0]       r_hex0;
    logic [6:0]       r_hex1;
    logic [6:0]       r_hex2;

    logic [3:0]       w_digit [3];
    logic [6:0]       w_seg   [3];
    logic [2:0]       w_blank;

    assign w_last_iter = (r_cnt == CNT_W'(ITER_COUNT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SHIFT;
            SHIFT:   if (w_last_iter) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Add-3 correction of every BCD nibble that is 5 or more, before the shift
    always_comb begin
        w_sr_adj = r_sr;
        for (int i = 0; i < 3; i++) begin
            if (r_sr[WIDTH + 4*i +: 4] >= 4'd5) begin
                w_sr_adj[WIDTH + 4*i +: 4] = r_sr[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath, display registers and done pulse
    always_ff @(posedge clk) begin
        if (clr) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
            r_hex0 <= SEG_BLANK;
            r_hex1 <= SEG_BLANK;
            r_hex2 <= SEG_BLANK;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sr  <= {12'd0, value};
                        r_ovf <= ovf;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_sr  <= {w_sr_adj[SR_W-2:0], 1'b0};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                LOAD: begin
                    r_hex0 <= r_ovf ? SEG_L : w_seg[0];
                    r_hex1 <= r_ovf ? SEG_F : w_seg[1];
                    r_hex2 <= r_ovf ? SEG_O : w_seg[2];
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Hundreds blank when zero; tens blank only when hundreds is also zero
    assign w_blank[0] = 1'b0;
    assign w_blank[1] = (BLANK_LZ != 0) && (w_digit[2] == 4'd0) && (w_digit[1] == 4'd0);
    assign w_blank[2] = (BLANK_LZ != 0) && (w_digit[2] == 4'd0);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            assign w_digit[gi] = r_sr[WIDTH + 4*gi +: 4];

            seg7_decode u_seg7_decode (
                .digit (w_digit[gi]),
                .blank (w_blank[gi]),
                .seg   (w_seg[gi])
            );
        end
    endgenerate

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign HEX0 = r_hex0;
    assign HEX1 = r_hex1;
    assign HEX2 = r_hex2;

endmodule
`default_nettype wire

// File: tb/tb_accum_bcd_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accum_bcd_display
//  Description : Self-checking bench for accum_bcd_display. Expected display
//                triples are pushed to a scoreboard when a start is driven
//                and popped when done is observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_bcd_display;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] value;
    logic       ovf;
    logic       start;
    logic       busy;
    logic       done;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;

    int n_checks = 0;
    int n_fail   = 0;
    int done_count = 0;

    logic [20:0] exp_q [$];

    accum_bcd_display #(
        .BLANK_LZ (1),
        .WIDTH    (8)
    ) dut (
        .clk   (clk),
        .clr   (clr),
        .value (value),
        .ovf   (ovf),
        .start (start),
        .busy  (busy),
        .done  (done),
        .HEX0  (HEX0),
        .HEX1  (HEX1),
        .HEX2  (HEX2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {HEX2, HEX1, HEX0} with leading-zero blanking and OFL override
    function automatic logic [20:0] model(input int v, input logic o);
        int h, t, u;
        logic [6:0] s2, s1, s0;
        if (o) return {7'b1000000, 7'b0001110, 7'b1000111};
        h  = v / 100;
        t  = (v / 10) % 10;
        u  = v % 10;
        s2 = (h == 0) ? 7'b1111111 : seg_of(h);
        s1 = (h == 0 && t == 0) ? 7'b1111111 : seg_of(t);
        s0 = seg_of(u);
        return {s2, s1, s0};
    endfunction

    // Called #1 after an edge; returns #1 after the capture edge N
    task automatic drive_start(input int v, input logic o);
        value = v[7:0];
        ovf   = o;
        start = 1'b1;
        exp_q.push_back(model(v, o));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after N until done; lat = -1 when the budget expires
    task automatic wait_done(output int lat, output int busy_hi);
        busy_hi = (busy === 1'b1) ? 1 : 0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                return;
            end
            if (busy === 1'b1) busy_hi++;
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int dc0;
        clr = 1'b1; start = 1'b0; value = 8'd0; ovf = 1'b0;
        cycles(2);
        n_checks++;
        if ({HEX2, HEX1, HEX0} !== {3{7'h7F}} || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: hex=%h_%h_%h busy=%b done=%b, required 7f_7f_7f busy=0 done=0",
                     HEX2, HEX1, HEX0, busy, done);
        end
        clr = 1'b0;
        dc0 = done_count;
        value = 8'd77;
        cycles(5);
        n_checks++;
        if ({HEX2, HEX1, HEX0} !== {3{7'h7F}} || busy !== 1'b0 || done_count != dc0) begin
            n_fail++;
            $display("FAIL idle_hold: hex=%h_%h_%h busy=%b dones=%0d, required 7f_7f_7f busy=0 dones=0",
                     HEX2, HEX1, HEX0, busy, done_count - dc0);
        end
    endtask

    task automatic test_convert(input int v, input logic o);
        int lat, bh;
        logic [20:0] exp_v;
        logic [20:0] prev;
        prev = {HEX2, HEX1, HEX0};
        drive_start(v, o);
        value = ~value;
        ovf   = ~ovf;
        cycles(4);
        n_checks++;
        if ({HEX2, HEX1, HEX0} !== prev) begin
            n_fail++;
            $display("FAIL hold_during_conv(%0d): hex=%h, required %h", v, {HEX2, HEX1, HEX0}, prev);
        end
        wait_done(lat, bh);
        lat = (lat < 0) ? lat : lat + 4;
        bh  = bh + 4;
        n_checks++;
        if (lat != 9 || bh != 9) begin
            n_fail++;
            $display("FAIL latency(%0d): done_at=N+%0d busy_cycles=%0d, required N+9 and 9", v, lat, bh);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({HEX2, HEX1, HEX0} !== exp_v || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL display(%0d,ovf=%b): hex=%b_%b_%b busy=%b, required %b_%b_%b busy=0",
                     v, o, HEX2, HEX1, HEX0, busy, exp_v[20:14], exp_v[13:7], exp_v[6:0]);
        end
        cycles(1);
        n_checks++;
        if (done !== 1'b0 || {HEX2, HEX1, HEX0} !== exp_v) begin
            n_fail++;
            $display("FAIL done_pulse(%0d): done=%b hex=%h one cycle later, required 0 and %h",
                     v, done, {HEX2, HEX1, HEX0}, exp_v);
        end
    endtask

    task automatic test_start_ignored();
        int lat, bh, dc0;
        logic [20:0] exp_v;
        dc0 = done_count;
        drive_start(42, 1'b0);
        cycles(2);
        value = 8'd99;
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        wait_done(lat, bh);
        n_checks++;
        if (lat != 6) begin
            n_fail++;
            $display("FAIL busy_start_latency: done_at=N+%0d, required N+9", (lat < 0) ? lat : lat + 3);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({HEX2, HEX1, HEX0} !== exp_v) begin
            n_fail++;
            $display("FAIL busy_start_display: hex=%b_%b_%b, required %b_%b_%b",
                     HEX2, HEX1, HEX0, exp_v[20:14], exp_v[13:7], exp_v[6:0]);
        end
        cycles(14);
        n_checks++;
        if (done_count - dc0 != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_single_done: dones=%0d busy=%b, required 1 and 0",
                     done_count - dc0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int dc0;
        dc0 = done_count;
        drive_start(128, 1'b0);
        void'(exp_q.pop_back());
        cycles(3);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        n_checks++;
        if ({HEX2, HEX1, HEX0} !== {3{7'h7F}} || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: hex=%h_%h_%h busy=%b, required 7f_7f_7f busy=0",
                     HEX2, HEX1, HEX0, busy);
        end
        cycles(1);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_n5: busy=%b done=%b, required 0 0", busy, done);
        end
        cycles(12);
        n_checks++;
        if (done_count != dc0 || {HEX2, HEX1, HEX0} !== {3{7'h7F}}) begin
            n_fail++;
            $display("FAIL mid_reset_no_done: dones=%0d hex=%h, required 0 and all 7f",
                     done_count - dc0, {HEX2, HEX1, HEX0});
        end
        test_convert(9, 1'b0);
    endtask

    task automatic test_clr_wins();
        clr   = 1'b1;
        start = 1'b1;
        value = 8'd55;
        cycles(1);
        clr   = 1'b0;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || {HEX2, HEX1, HEX0} !== {3{7'h7F}}) begin
            n_fail++;
            $display("FAIL clr_wins: busy=%b hex=%h, required 0 and all 7f", busy, {HEX2, HEX1, HEX0});
        end
    endtask

    initial begin
        test_reset();
        test_convert(255, 1'b0);
        test_convert(0, 1'b0);
        test_convert(107, 1'b0);
        test_convert(200, 1'b1);
        test_convert(58, 1'b0);
        test_start_ignored();
        test_reset_mid();
        test_clr_wins();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
